prog_seq_counter: RTL and testbench
===================================

# prog_seq_counter

Parametrised synchronous sequence counter: steps through a programmable table of up to DEPTH WIDTH-bit codes and presents the current code on `qout`. The table, the active sequence length and the direction are run-time controls, and the counter supports enable, synchronous clear and index load. It generalises the team's fixed-sequence counters and is the common sequence source for counter, timer and test-pattern users in the design.

## Interface
- `WIDTH`, 4: bit width of each sequence code and of `qout`.
- `DEPTH`, 8: table entries (≥2); IW = $clog2(DEPTH), LW = $clog2(DEPTH+1).
- `clk`  in  1  rising-edge clock (single clock domain).
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  advance one table entry this cycle.
- `dir`  in  1  1 = up (idx+1), 0 = down (idx−1).
- `clr`  in  1  synchronous: idx ← 0.
- `ld`  in  1  synchronous: idx ← `ld_idx`.
- `ld_idx`  in  IW  index to load; values ≥ active length load 0.
- `cfg_len`  in  LW  active sequence length; 0 or >DEPTH means DEPTH.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  IW  table entry to write; ≥DEPTH ignored.
- `wr_data`  in  WIDTH  code to store.
- `idx`  out  IW  current table index (register).
- `qout`  out  WIDTH  table[idx], combinational from registers.
- `wrap`  out  1  combinational: `en` & ~`clr` & ~`ld` & (up & idx==L−1 | down & idx==0).

## Operation
- L = effective length (resolved from `cfg_len`). Up step: idx==L−1 or idx≥L → 0, else idx+1. Down step: idx==0 → L−1; idx≥L → L−1; else idx−1.
- Per-edge priority: `clr` > `ld` > `en` step > hold. `dir` is sampled only when stepping.
- Table writes are independent of index control. A write and a step in the same cycle both take effect. A write to the entry idx will hold after the edge is visible on `qout` immediately after that edge.
- Changing `cfg_len` mid-run never stalls the counter. An out-of-range idx is corrected on the next step per the rules above, and `wrap` counts as asserting at idx≥L−1 when stepping up.
- Reset: idx = 0; table = default sequence 0,1,3,7,9,11,13,14 for WIDTH=4, DEPTH=8. For other parameters, entry k resets to k mod 2^WIDTH, and defaults beyond DEPTH are dropped. After reset, `qout` = table[0] (0) and `wrap` = 0 while `en` = 0.
- Reset assertion mid-operation restores idx and the full table asynchronously; no write in flight survives.

## Timing
- All state changes on the rising `clk` edge. `qout` and `wrap` have zero-cycle latency from register state.
- `en` held high: a new code every cycle; the full sequence repeats every L cycles.
- `ld`/`clr` take effect at the edge they are sampled on; the following cycle shows table[new idx].
- Release of `rst_n` is asynchronous to the design; the first step occurs at the first edge with `rst_n` high and `en` high.

## Structure
- Package `prog_seq_counter_pkg`: default sequence constant (array of 8×4-bit), helper function returning reset value of entry k for given WIDTH/DEPTH, and the length-resolution function.
- Sub-module `seq_table`: DEPTH×WIDTH register file with async reset to defaults, one write port, one combinational read port. Index/length control logic stays in the top.

## Test plan
- Reset, then `en`=1, `dir`=1, `cfg_len`=0 for 10 cycles -> `qout` 0,1,3,7,9,11,13,14,0,1; `wrap` high only in the cycle with `qout`=14.
- From idx 0 with `dir`=0 and `en`=1 -> `qout` 14,13,11 on the next three cycles; `wrap` high in the idx-0 cycle.
- `cfg_len`=3 with up stepping -> `qout` 0,1,3,0,1,3; at idx 6, set `cfg_len`=3 and step up -> idx 0, `wrap`=1 that cycle.
- `clr`, `ld` (`ld_idx`=5) and `en` in the same cycle -> idx=0. `ld`=1 with `ld_idx`=5 and `en`=1 -> idx=5, `qout`=11. `ld_idx`=6 with `cfg_len`=4 -> idx=0.
- Write `wr_addr`=2 / `wr_data`=0xA while idx=1 and stepping up -> next cycle idx=2, `qout`=0xA. Write with `wr_addr`=current idx and `en`=0 -> `qout` changes after that edge.
- Assert `rst_n` low mid-sequence after table writes -> idx=0, `qout`=0 immediately (asynchronously), and the default table is restored, checked by a full up-count.

Source files
------------

// File: rtl/prog_seq_counter_pkg.sv
// prog_seq_counter_pkg: default sequence table, per-entry reset values and length resolution
package prog_seq_counter_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 8;

    localparam logic [DEF_WIDTH-1:0] DEFAULT_SEQ [DEF_DEPTH] = '{
        4'd0, 4'd1, 4'd3, 4'd7, 4'd9, 4'd11, 4'd13, 4'd14
    };

    // The default sequence applies to 4-bit tables of up to 8 entries; any other shape counts k mod 2^width.
    function automatic int unsigned reset_code(
        input int unsigned k,
        input int unsigned width,
        input int unsigned depth
    );
        if (width == 32'(DEF_WIDTH) && depth <= 32'(DEF_DEPTH))
            return 32'(DEFAULT_SEQ[k[2:0]]);
        return (width >= 32) ? k : (k & ((32'd1 << width) - 32'd1));
    endfunction

    function automatic int unsigned eff_len(
        input int unsigned cfg,
        input int unsigned depth
    );
        return (cfg == 0 || cfg > depth) ? depth : cfg;
    endfunction

endpackage

// File: rtl/prog_seq_counter_seq_table.sv
// seq_table: DEPTH x WIDTH code table, async reset to defaults, one write port, one combinational read port
module seq_table
    import prog_seq_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic             rd_ok;

    assign wr_ok   = 32'(wr_addr) < 32'(DEPTH);
    assign rd_ok   = 32'(rd_addr) < 32'(DEPTH);
    assign rd_data = rd_ok ? mem[rd_addr] : '0;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int k = 0; k < DEPTH; k++)
                mem[k] <= WIDTH'(reset_code(32'(k), 32'(WIDTH), 32'(DEPTH)));
        else if (wr_en && wr_ok)
            mem[wr_addr] <= wr_data;

endmodule

// File: rtl/prog_seq_counter.sv
// prog_seq_counter: steps through a programmable code table with clear, load, enable and direction
module prog_seq_counter
    import prog_seq_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    localparam int IW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic             clr,
    input  logic             ld,
    input  logic [IW-1:0]    ld_idx,
    input  logic [LW-1:0]    cfg_len,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [IW-1:0]    idx,
    output logic [WIDTH-1:0] qout,
    output logic             wrap
);

    logic [LW-1:0] len;
    logic [LW-1:0] idx_w;
    logic [IW-1:0] last;
    logic [IW-1:0] step_up;
    logic [IW-1:0] step_dn;
    logic [IW-1:0] ld_val;
    logic          at_top;
    logic          at_zero;
    logic          over;

    assign len     = LW'(eff_len(32'(cfg_len), 32'(DEPTH)));
    assign idx_w   = LW'(idx);
    assign last    = IW'(len - LW'(1));
    assign over    = idx_w >= len;
    // at_top also covers an index stranded above a freshly shortened length
    assign at_top  = idx_w >= len - LW'(1);
    assign at_zero = idx == '0;
    assign step_up = at_top ? '0 : idx + IW'(1);
    assign step_dn = (at_zero || over) ? last : idx - IW'(1);
    assign ld_val  = (LW'(ld_idx) >= len) ? '0 : ld_idx;
    assign wrap    = en & ~clr & ~ld & (dir ? at_top : at_zero);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            idx <= '0;
        else if (clr)
            idx <= '0;
        else if (ld)
            idx <= ld_val;
        else if (en)
            idx <= dir ? step_up : step_dn;

    seq_table #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_table (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(idx),
        .rd_data(qout)
    );

endmodule

// File: tb/tb_prog_seq_counter.sv
// tb_prog_seq_counter: scoreboard bench, one task per scenario
module tb_prog_seq_counter;

    typedef struct {
        int en, dir, clr, ld, li, len, we, wa, wd, xi, xq, xw;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       en, dir, clr, ld;
    logic [2:0] ld_idx;
    logic [3:0] cfg_len;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [2:0] idx;
    logic [3:0] qout;
    logic       wrap;

    logic [7:0] sb [$];
    int checks;
    int failures;

    prog_seq_counter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .dir    (dir),
        .clr    (clr),
        .ld     (ld),
        .ld_idx (ld_idx),
        .cfg_len(cfg_len),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .idx    (idx),
        .qout   (qout),
        .wrap   (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input vec_t v);
        en      = v.en[0];
        dir     = v.dir[0];
        clr     = v.clr[0];
        ld      = v.ld[0];
        ld_idx  = 3'(v.li);
        cfg_len = 4'(v.len);
        wr_en   = v.we[0];
        wr_addr = 3'(v.wa);
        wr_data = 4'(v.wd);
        sb.push_back({3'(v.xi), 4'(v.xq), v.xw[0]});
    endtask

    task automatic test_reset();
        logic [7:0] e;
        rst_n = 1'b0;
        drive('{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        #7;
        e = sb.pop_front();
        checks++;
        if ({idx, qout, wrap} !== e) begin
            failures++;
            $display("FAIL reset idx/qout/wrap got %0d/%h/%b expected %0d/%h/%b", idx, qout, wrap, e[7:5], e[4:1], e[0]);
        end
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_up_count();
        logic [7:0] e;
        int seq [10] = '{0, 1, 3, 7, 9, 11, 13, 14, 0, 1};
        for (int i = 0; i < 10; i++) begin
            drive('{1, 1, 0, 0, 0, 0, 0, 0, 0, i % 8, seq[i], (i == 7) ? 1 : 0});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({idx, qout, wrap} !== e) begin
                failures++;
                $display("FAIL up_count[%0d] idx/qout/wrap got %0d/%h/%b expected %0d/%h/%b", i, idx, qout, wrap, e[7:5], e[4:1], e[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_down_count();
        vec_t v [$];
        logic [7:0] e;
        v.push_back('{0, 1, 1, 0, 0, 0, 0, 0, 0, 2, 3, 0});
        v.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
        v.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 14, 0});
        v.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 6, 13, 0});
        v.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 11, 0});
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({idx, qout, wrap} !== e) begin
                failures++;
                $display("FAIL down_count[%0d] idx/qout/wrap got %0d/%h/%b expected %0d/%h/%b", i, idx, qout, wrap, e[7:5], e[4:1], e[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_short_len();
        vec_t v [$];
        logic [7:0] e;
        int s3 [3] = '{0, 1, 3};
        v.push_back('{0, 1, 1, 0, 0, 3, 0, 0, 0, 5, 11, 0});
        for (int i = 0; i < 6; i++)
            v.push_back('{1, 1, 0, 0, 0, 3, 0, 0, 0, i % 3, s3[i % 3], (i % 3 == 2) ? 1 : 0});
        v.push_back('{0, 1, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0});
        v.push_back('{1, 1, 0, 0, 0, 3, 0, 0, 0, 6, 13, 1});
        v.push_back('{0, 1, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0});
        v.push_back('{1, 0, 0, 0, 0, 3, 0, 0, 0, 6, 13, 0});
        v.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 3, 0});
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({idx, qout, wrap} !== e) begin
                failures++;
                $display("FAIL short_len[%0d] idx/qout/wrap got %0d/%h/%b expected %0d/%h/%b", i, idx, qout, wrap, e[7:5], e[4:1], e[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_clr_ld();
        vec_t v [$];
        logic [7:0] e;
        v.push_back('{1, 1, 1, 1, 5, 0, 0, 0, 0, 2, 3, 0});
        v.push_back('{1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0});
        v.push_back('{0, 1, 0, 1, 6, 4, 0, 0, 0, 5, 11, 0});
        v.push_back('{0, 1, 0, 1, 3, 4, 0, 0, 0, 0, 0, 0});
        v.push_back('{1, 1, 0, 0, 0, 4, 0, 0, 0, 3, 7, 1});
        v.push_back('{0, 1, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0});
        v.push_back('{1, 1, 1, 0, 0, 0, 0, 0, 0, 7, 14, 0});
        v.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({idx, qout, wrap} !== e) begin
                failures++;
                $display("FAIL clr_ld[%0d] idx/qout/wrap got %0d/%h/%b expected %0d/%h/%b", i, idx, qout, wrap, e[7:5], e[4:1], e[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_write();
        vec_t v [$];
        logic [7:0] e;
        v.push_back('{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        v.push_back('{1, 1, 0, 0, 0, 0, 1, 2, 10, 1, 1, 0});
        v.push_back('{0, 1, 0, 0, 0, 0, 1, 2, 5, 2, 10, 0});
        v.push_back('{1, 1, 0, 0, 0, 0, 1, 3, 15, 2, 5, 0});
        v.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, 3, 15, 0});
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({idx, qout, wrap} !== e) begin
                failures++;
                $display("FAIL write[%0d] idx/qout/wrap got %0d/%h/%b expected %0d/%h/%b", i, idx, qout, wrap, e[7:5], e[4:1], e[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        vec_t v [$];
        logic [7:0] e;
        v.push_back('{1, 1, 0, 0, 0, 0, 1, 4, 2, 3, 15, 0});
        v.push_back('{1, 1, 0, 0, 0, 0, 1, 5, 4, 4, 2, 0});
        v.push_back('{1, 1, 0, 0, 0, 0, 1, 7, 6, 5, 4, 0});
        v.push_back('{1, 1, 0, 0, 0, 0, 0, 0, 0, 6, 13, 0});
        v.push_back('{1, 1, 0, 0, 0, 0, 0, 0, 0, 7, 6, 1});
        v.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({idx, qout, wrap} !== e) begin
                failures++;
                $display("FAIL back_to_back[%0d] idx/qout/wrap got %0d/%h/%b expected %0d/%h/%b", i, idx, qout, wrap, e[7:5], e[4:1], e[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_reset();
        vec_t v [$];
        logic [7:0] e;
        int seq [10] = '{0, 1, 3, 7, 9, 11, 13, 14, 0, 1};
        v.push_back('{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        v.push_back('{1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0});
        v.push_back('{1, 1, 0, 0, 0, 0, 0, 0, 0, 2, 5, 0});
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({idx, qout, wrap} !== e) begin
                failures++;
                $display("FAIL pre_reset[%0d] idx/qout/wrap got %0d/%h/%b expected %0d/%h/%b", i, idx, qout, wrap, e[7:5], e[4:1], e[0]);
            end
            if (i < 2) begin
                @(posedge clk); #1;
            end
        end
        #2 rst_n = 1'b0;
        drive('{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        #1;
        e = sb.pop_front();
        checks++;
        if ({idx, qout, wrap} !== e) begin
            failures++;
            $display("FAIL async_reset idx/qout/wrap got %0d/%h/%b expected %0d/%h/%b", idx, qout, wrap, e[7:5], e[4:1], e[0]);
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            drive('{1, 1, 0, 0, 0, 0, 0, 0, 0, i % 8, seq[i], (i == 7) ? 1 : 0});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({idx, qout, wrap} !== e) begin
                failures++;
                $display("FAIL restored_table[%0d] idx/qout/wrap got %0d/%h/%b expected %0d/%h/%b", i, idx, qout, wrap, e[7:5], e[4:1], e[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_up_count();
        test_down_count();
        test_short_len();
        test_clr_ld();
        test_write();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
